// File: rtl/dft_pkg.sv
// Shared definitions for the DFT stream controller and the dft_block it feeds.
package dft_pkg;

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FETCH = 2'd2,
      ST_EMIT  = 2'd3
   } state_t;

   localparam int NPOINTS = 8;
   localparam logic [7:0] DFT_BASE_ADR = 8'hF8;

endpackage

// File: rtl/dft_stream_ctrl.sv
// Feeds an 8-sample frame into dft_block's input registers, then drains Y0..Y7
// from its output registers onto a valid/ready result stream.
module dft_stream_ctrl
   import dft_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] BASE_ADR = WIDTH'(DFT_BASE_ADR),
   parameter int               SETTLE   = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_last,
   output logic             busy,
   output logic             memwrite,
   output logic [WIDTH-1:0] adr,
   output logic [WIDTH-1:0] writedata,
   input  logic [WIDTH-1:0] memdata
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; a raised valid keeps its data stable until that transfer.
   localparam int SW   = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
   localparam int LAST = NPOINTS - 1;

   state_t           state, state_n;
   logic [2:0]       cnt, cnt_n;
   logic [SW-1:0]    settle_cnt, settle_n;
   logic             memwrite_n, out_valid_n, out_last_n;
   logic [WIDTH-1:0] adr_n, writedata_n, out_data_n;

   function automatic logic [WIDTH-1:0] slot_adr(input logic [2:0] i);
      return {BASE_ADR[WIDTH-1:3], i};
   endfunction

   assign in_ready = (state == ST_LOAD);
   assign busy     = (state != ST_LOAD) || (cnt != 3'd0);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      settle_n    = settle_cnt;
      memwrite_n  = 1'b0;
      adr_n       = adr;
      writedata_n = writedata;
      out_data_n  = out_data;
      out_valid_n = out_valid;
      out_last_n  = out_last;
      case (state)
         ST_LOAD: begin
            if (in_valid) begin
               memwrite_n  = 1'b1;
               adr_n       = slot_adr(cnt);
               writedata_n = in_data;
               cnt_n       = cnt + 3'd1;
               if (cnt == 3'(LAST)) begin
                  state_n  = ST_WAIT;
                  settle_n = SW'(SETTLE);
               end
            end
         end
         // Counts SETTLE down to 0, giving SETTLE+1 cycles for the DFT outputs to settle.
         ST_WAIT: begin
            if (settle_cnt == '0) begin
               state_n = ST_FETCH;
               adr_n   = BASE_ADR;
            end else begin
               settle_n = settle_cnt - SW'(1);
            end
         end
         ST_FETCH: begin
            out_data_n  = memdata;
            out_valid_n = 1'b1;
            out_last_n  = (cnt == 3'(LAST));
            state_n     = ST_EMIT;
         end
         ST_EMIT: begin
            if (out_ready) begin
               out_valid_n = 1'b0;
               if (cnt == 3'(LAST)) begin
                  out_last_n = 1'b0;
                  cnt_n      = 3'd0;
                  state_n    = ST_LOAD;
               end else begin
                  cnt_n   = cnt + 3'd1;
                  adr_n   = slot_adr(cnt + 3'd1);
                  state_n = ST_FETCH;
               end
            end
         end
         default: state_n = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_LOAD;
         cnt        <= 3'd0;
         settle_cnt <= '0;
         memwrite   <= 1'b0;
         adr        <= BASE_ADR;
         writedata  <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         settle_cnt <= settle_n;
         memwrite   <= memwrite_n;
         adr        <= adr_n;
         writedata  <= writedata_n;
         out_data   <= out_data_n;
         out_valid  <= out_valid_n;
         out_last   <= out_last_n;
      end
   end

endmodule

// File: tb/tb_dft_stream_ctrl.sv
// Bench for dft_stream_ctrl paired with a pass-through stand-in of dft_block (Yk = Xk).
module tb_dft_stream_ctrl;
   import dft_pkg::*;

   localparam int         W      = 8;
   localparam int         SETTLE = 2;
   localparam logic [7:0] BASE   = 8'hF8;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid, in_ready, out_valid, out_ready, out_last, busy, memwrite;
   logic [W-1:0] in_data, out_data, adr, writedata, memdata;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dft_stream_ctrl #(.WIDTH(W), .BASE_ADR(BASE), .SETTLE(SETTLE)) dut (
      .clk(clk), .reset(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .busy(busy), .memwrite(memwrite), .adr(adr), .writedata(writedata), .memdata(memdata)
   );

   // dft_block stand-in: eight registers decoded at 0xF8..0xFF, pass-through outputs
   logic [W-1:0] dft_x [8];
   initial for (int i = 0; i < 8; i++) dft_x[i] = '0;
   always @(posedge clk) if (memwrite && adr[7:3] == 5'h1F) dft_x[adr[2:0]] <= writedata;
   assign memdata = dft_x[adr[2:0]];

   // Reference model: accepted samples queue up as expected results; each accept
   // must produce exactly one write pulse in the following cycle.
   logic [W-1:0] exp_q [$];
   logic [W-1:0] src_q [$];
   int           in_idx = 0, out_k = 0;
   bit           model_busy = 0, pend_v = 0, prev_valid = 0;
   logic [W-1:0] pend_adr, pend_data, exp_v;
   int           acc_last_cyc = 0, valid_rise_cyc = 0;

   always @(negedge clk) begin
      if (rst) begin
         in_idx = 0; out_k = 0; model_busy = 0; pend_v = 0; prev_valid = 0;
         exp_q.delete();
      end else begin
         checks++;
         if (in_ready !== !model_busy) begin
            errors++; $display("FAIL in_ready @%0d: got %b expected %b", cyc, in_ready, !model_busy);
         end
         checks++;
         if (busy !== (model_busy || in_idx != 0)) begin
            errors++; $display("FAIL busy @%0d: got %b expected %b", cyc, busy, model_busy || in_idx != 0);
         end
         checks++;
         if (memwrite !== pend_v || (pend_v && (adr !== pend_adr || writedata !== pend_data))) begin
            errors++;
            $display("FAIL write @%0d: got we=%b adr=%h wd=%h expected we=%b adr=%h wd=%h",
                     cyc, memwrite, adr, writedata, pend_v, pend_adr, pend_data);
         end
         if (out_valid && !prev_valid && out_k == 0) valid_rise_cyc = cyc;
         prev_valid = out_valid;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL result_extra @%0d: got %h with nothing expected", cyc, out_data);
            end else begin
               exp_v = exp_q.pop_front();
               if (out_data !== exp_v || out_last !== (out_k == 7)) begin
                  errors++;
                  $display("FAIL result k=%0d: got data=%h last=%b expected data=%h last=%b",
                           out_k, out_data, out_last, exp_v, out_k == 7);
               end
            end
            out_k++;
            if (out_k == 8) begin out_k = 0; model_busy = 0; end
         end
         pend_v = 0;
         if (in_valid && in_ready) begin
            pend_v    = 1;
            pend_adr  = BASE | W'(in_idx);
            pend_data = in_data;
            exp_q.push_back(in_data);
            in_idx++;
            if (in_idx == 8) begin in_idx = 0; model_busy = 1; acc_last_cyc = cyc + 1; end
         end
      end
   end

   // mode 0: in_valid always high, 1: low every other cycle, 2: random gaps
   task automatic drive_src(input int mode);
      int guard = 0;
      bit acc, toggle = 1;
      while (src_q.size() > 0 && guard < 2000) begin
         case (mode)
            0:       in_valid = 1'b1;
            1:       begin in_valid = toggle; toggle = !toggle; end
            default: in_valid = ($urandom_range(0, 3) != 0);
         endcase
         in_data = src_q[0];
         @(negedge clk); acc = in_valid && in_ready;
         @(posedge clk); #1;
         if (acc) void'(src_q.pop_front());
         guard++;
      end
      in_valid = 1'b0;
      checks++;
      if (src_q.size() != 0) begin
         errors++; $display("FAIL src_timeout: got %0d samples left expected 0", src_q.size());
      end
   endtask

   // mode 0: out_ready always high, otherwise random
   task automatic sink_n(input int n, input int mode);
      int got = 0, guard = 0;
      while (got < n && guard < 3000) begin
         out_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         @(negedge clk); if (out_valid && out_ready) got++;
         @(posedge clk); #1;
         guard++;
      end
      out_ready = 1'b0;
      checks++;
      if (got != n) begin
         errors++; $display("FAIL sink_timeout: got %0d results expected %0d", got, n);
      end
   endtask

   task automatic load_frame(input logic [W-1:0] first, input int step);
      for (int i = 0; i < 8; i++) src_q.push_back(first + W'(i * step));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({memwrite, adr, writedata} !== {1'b0, BASE, 8'h00}) begin
         errors++; $display("FAIL reset_bus: got we=%b adr=%h wd=%h expected 0 f8 00", memwrite, adr, writedata);
      end
      checks++;
      if ({out_valid, out_data, out_last} !== {1'b0, 8'h00, 1'b0}) begin
         errors++; $display("FAIL reset_out: got v=%b d=%h l=%b expected 0 00 0", out_valid, out_data, out_last);
      end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_flags: got in_ready=%b busy=%b expected 1 0", in_ready, busy);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_frame_basic();
      load_frame(8'h10, 1);
      fork
         drive_src(0);
         sink_n(8, 0);
      join
      checks++;
      if (valid_rise_cyc - acc_last_cyc != SETTLE + 2) begin
         errors++; $display("FAIL latency: got %0d edges expected %0d", valid_rise_cyc - acc_last_cyc, SETTLE + 2);
      end
   endtask

   task automatic test_gapped();
      load_frame(8'hA0, 1);
      fork
         drive_src(1);
         sink_n(8, 0);
      join
   endtask

   task automatic test_backpressure();
      int got = 0, guard = 0;
      bit stalled = 0;
      load_frame(8'h10, 1);
      fork
         drive_src(0);
         begin
            while (got < 8 && guard < 500) begin
               out_ready = 1'b1;
               if (got == 3 && !stalled && out_valid) begin
                  out_ready = 1'b0;
                  stalled   = 1;
                  for (int i = 0; i < 5; i++) begin
                     @(negedge clk);
                     checks++;
                     if (out_valid !== 1'b1 || out_data !== 8'h13 || adr !== 8'hFB) begin
                        errors++;
                        $display("FAIL stall_hold %0d: got v=%b d=%h adr=%h expected 1 13 fb", i, out_valid, out_data, adr);
                     end
                     @(posedge clk); #1;
                  end
                  out_ready = 1'b1;
               end
               @(negedge clk); if (out_valid && out_ready) got++;
               @(posedge clk); #1;
               guard++;
            end
            out_ready = 1'b0;
            checks++;
            if (got != 8 || !stalled) begin
               errors++; $display("FAIL stall_done: got %0d results stalled=%b expected 8 1", got, stalled);
            end
         end
      join
   endtask

   task automatic test_back_to_back();
      load_frame(8'h00, 1);
      load_frame(8'hFF, -1);
      fork
         drive_src(0);
         sink_n(16, 0);
      join
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) src_q.push_back(8'h20 + W'(i));
      drive_src(0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({memwrite, adr, writedata, out_valid, out_data, out_last} !== {1'b0, BASE, 8'h00, 1'b0, 8'h00, 1'b0}) begin
         errors++; $display("FAIL mid_reset_out: got we=%b adr=%h wd=%h v=%b expected 0 f8 00 0", memwrite, adr, writedata, out_valid);
      end
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL mid_reset_flags: got in_ready=%b busy=%b expected 1 0", in_ready, busy);
      end
      @(negedge clk);
      @(posedge clk); #1 rst = 1'b0;
      load_frame(8'h20, 1);
      fork
         drive_src(0);
         sink_n(8, 0);
      join
   endtask

   task automatic test_random();
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < 8; i++) src_q.push_back(W'($urandom));
         fork
            drive_src(2);
            sink_n(8, 1);
         join
      end
   endtask

   initial begin
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_frame_basic();
      test_gapped();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      repeat (4) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL drain: got %0d results outstanding expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
